// File: rtl/ipf_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ipf_seq_ctrl
//  Description : Job sequencer for the IPF multiply/accumulate engine.
//                Per job, it loads one weight set (3x3 or 5x5) from a 64-bit
//                read-only operand memory. It then streams the input tile once
//                per weight group, using the HOLD/START control pattern, and
//                finally issues END and waits for ipf_finish.
//  Ports       : clk, rst (async, active-low)
//                cfg_*        job configuration, cfg_start is a 1-cycle request
//                mem_rd_en/mem_addr/mem_rdata  operand memory (1-cycle latency)
//                ipf_finish   completion flag from IPF
//                w_valid/w_data, i_valid/i_data, ctrl, Wsize, wgroup, wround,
//                stride, RLPadding  IPF-side outputs (registered, stage B)
//                busy, done, cfg_err  job status
//  Revision    : 1.0  initial release
// ============================================================================
module ipf_seq_ctrl #(
   parameter int ADDR_W    = 16,
   parameter int W_WORDS3  = 18,
   parameter int W_WORDS5  = 25,
   parameter int I_WORDS   = 8,
   parameter int PRE_WORDS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_start,
   input  logic [1:0]        cfg_wsize,
   input  logic [3:0]        cfg_ngroup,
   input  logic [ADDR_W-1:0] cfg_wbase,
   input  logic [ADDR_W-1:0] cfg_ibase,
   input  logic              cfg_stride,
   input  logic [1:0]        cfg_rlpad,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [63:0]       mem_rdata,
   input  logic              ipf_finish,
   output logic              w_valid,
   output logic [63:0]       w_data,
   output logic              i_valid,
   output logic [63:0]       i_data,
   output logic [1:0]        ctrl,
   output logic [1:0]        Wsize,
   output logic [3:0]        wgroup,
   output logic [2:0]        wround,
   output logic              stride,
   output logic [1:0]        RLPadding,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   // Word counter is shared by the weight phase and the input phase, so it
   // must hold the largest per-phase count.
   localparam int c_MAXW_WI = (W_WORDS3 > W_WORDS5) ? W_WORDS3 : W_WORDS5;
   localparam int c_MAXW    = (c_MAXW_WI > I_WORDS) ? c_MAXW_WI : I_WORDS;
   localparam int CNT_W     = (c_MAXW > 2) ? $clog2(c_MAXW) : 1;

   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_LOADW = 3'd1;
   localparam logic [2:0] c_ST_PRE   = 3'd2;
   localparam logic [2:0] c_ST_RUN   = 3'd3;
   localparam logic [2:0] c_ST_ENDW  = 3'd4;

   localparam logic [1:0] c_CTRL_END   = 2'd0;
   localparam logic [1:0] c_CTRL_START = 2'd1;
   localparam logic [1:0] c_CTRL_HOLD  = 2'd2;

   // ------------------------------------------------------------------ state
   logic [2:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [3:0]        r_grp;
   logic [3:0]        r_ngroup;
   logic [ADDR_W-1:0] r_wbase;
   logic [ADDR_W-1:0] r_ibase;
   logic [1:0]        r_wsize;
   logic              r_stride;
   logic [1:0]        r_rlpad;

   // Stage A tags: describe the read issued this cycle, so that stage B can
   // pair them with mem_rdata when it returns one cycle later.
   logic              r_p_wv;
   logic              r_p_iv;
   logic [1:0]        r_p_ctrl;
   logic [3:0]        r_p_grp;

   // ------------------------------------------------------------ decode
   logic w_start_ok;
   logic w_wlast;
   logic w_prelast;
   logic w_ilast;
   logic w_more;
   logic w_fin;

   assign w_start_ok = cfg_start && (cfg_wsize <= 2'd1) && (cfg_ngroup != 4'd0);
   assign w_wlast    = (r_cnt == (r_wsize[0] ? CNT_W'(W_WORDS5 - 1) : CNT_W'(W_WORDS3 - 1)));
   assign w_prelast  = (r_cnt == CNT_W'(PRE_WORDS - 1));
   assign w_ilast    = (r_cnt == CNT_W'(I_WORDS - 1));
   assign w_more     = (({1'b0, r_grp} + 5'd1) < {1'b0, r_ngroup});
   // Finish is only honoured once END is actually on the IPF interface, so
   // the last START-tagged input word can never be overtaken by HOLD.
   assign w_fin      = (r_state == c_ST_ENDW) && (ctrl == c_CTRL_END) && ipf_finish;

   // ---------------------------------------------------------- stage A
   assign mem_rd_en = (r_state == c_ST_LOADW) || (r_state == c_ST_PRE) || (r_state == c_ST_RUN);
   assign mem_addr  = !mem_rd_en ? '0 :
                      ((r_state == c_ST_LOADW) ? r_wbase : r_ibase) + ADDR_W'(r_cnt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= c_ST_IDLE;
         r_cnt    <= '0;
         r_grp    <= '0;
         r_ngroup <= '0;
         r_wbase  <= '0;
         r_ibase  <= '0;
         r_wsize  <= '0;
         r_stride <= 1'b0;
         r_rlpad  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (cfg_start) begin
                  if (w_start_ok) begin
                     r_wsize  <= cfg_wsize;
                     r_ngroup <= cfg_ngroup;
                     r_wbase  <= cfg_wbase;
                     r_ibase  <= cfg_ibase;
                     r_stride <= cfg_stride;
                     r_rlpad  <= cfg_rlpad;
                     r_cnt    <= '0;
                     r_grp    <= '0;
                     busy     <= 1'b1;
                     r_state  <= c_ST_LOADW;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            c_ST_LOADW: begin
               if (w_wlast) begin
                  r_cnt   <= '0;
                  r_grp   <= '0;
                  r_state <= c_ST_PRE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            c_ST_PRE: begin
               // Counter keeps running into RUN: it is the input-word offset.
               r_cnt <= r_cnt + 1'b1;
               if (w_prelast) begin
                  r_state <= c_ST_RUN;
               end
            end
            c_ST_RUN: begin
               if (w_ilast) begin
                  r_cnt <= '0;
                  if (w_more) begin
                     r_grp   <= r_grp + 1'b1;
                     r_state <= c_ST_PRE;
                  end else begin
                     r_state <= c_ST_ENDW;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            c_ST_ENDW: begin
               if (w_fin) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= c_ST_IDLE;
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_p_wv   <= 1'b0;
         r_p_iv   <= 1'b0;
         r_p_ctrl <= c_CTRL_HOLD;
         r_p_grp  <= '0;
      end else begin
         r_p_wv  <= (r_state == c_ST_LOADW);
         r_p_iv  <= (r_state == c_ST_PRE) || (r_state == c_ST_RUN);
         r_p_grp <= r_grp;
         if (r_state == c_ST_RUN) begin
            r_p_ctrl <= c_CTRL_START;
         end else if ((r_state == c_ST_ENDW) && !w_fin) begin
            r_p_ctrl <= c_CTRL_END;
         end else begin
            r_p_ctrl <= c_CTRL_HOLD;
         end
      end
   end

   // ---------------------------------------------------------- stage B
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_valid <= 1'b0;
         i_valid <= 1'b0;
         w_data  <= '0;
         i_data  <= '0;
         ctrl    <= c_CTRL_HOLD;
         wgroup  <= '0;
      end else begin
         w_valid <= r_p_wv;
         i_valid <= r_p_iv;
         wgroup  <= r_p_grp;
         if (r_p_wv) begin
            w_data <= mem_rdata;
         end
         if (r_p_iv) begin
            i_data <= mem_rdata;
         end
         // On finish, return to HOLD immediately rather than waiting for the
         // HOLD tag to ripple through stage A.
         ctrl <= w_fin ? c_CTRL_HOLD : r_p_ctrl;
      end
   end

   assign Wsize     = r_wsize;
   assign stride    = r_stride;
   assign RLPadding = r_rlpad;
   assign wround    = 3'd0;

endmodule
`default_nettype wire

// File: tb/tb_ipf_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ipf_seq_ctrl
//  Description : Self-checking bench for ipf_seq_ctrl. Jobs push their
//                expected IPF word stream into a queue; a monitor pops and
//                compares on every w_valid/i_valid strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ipf_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cfg_start = 1'b0;
   logic [1:0]  cfg_wsize = '0;
   logic [3:0]  cfg_ngroup = '0;
   logic [15:0] cfg_wbase = '0;
   logic [15:0] cfg_ibase = '0;
   logic        cfg_stride = 1'b0;
   logic [1:0]  cfg_rlpad = '0;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [63:0] mem_rdata = '0;
   logic        ipf_finish = 1'b0;
   logic        w_valid, i_valid;
   logic [63:0] w_data, i_data;
   logic [1:0]  ctrl, Wsize, RLPadding;
   logic [3:0]  wgroup;
   logic [2:0]  wround;
   logic        stride, busy, done, cfg_err;

   ipf_seq_ctrl dut (
      .clk(clk), .rst(rst),
      .cfg_start(cfg_start), .cfg_wsize(cfg_wsize), .cfg_ngroup(cfg_ngroup),
      .cfg_wbase(cfg_wbase), .cfg_ibase(cfg_ibase), .cfg_stride(cfg_stride),
      .cfg_rlpad(cfg_rlpad),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .ipf_finish(ipf_finish),
      .w_valid(w_valid), .w_data(w_data), .i_valid(i_valid), .i_data(i_data),
      .ctrl(ctrl), .Wsize(Wsize), .wgroup(wgroup), .wround(wround),
      .stride(stride), .RLPadding(RLPadding),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   // Operand memory contents are a fixed function of the address.
   function automatic logic [63:0] memf(input logic [15:0] a);
      return {a ^ 16'h5A3C, ~a, a + 16'h1234, a[7:0], a[15:8]};
   endfunction

   always @(posedge clk) mem_rdata <= memf(mem_addr);

   typedef struct packed {
      logic        isw;
      logic [63:0] data;
      logic [1:0]  ctl;
      logic [3:0]  grp;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every strobe consumes one expected word.
   always @(negedge clk) begin
      if (rst && (w_valid || i_valid)) begin
         if (q.size() == 0) begin
            chk("unexpected_strobe", {62'd0, w_valid, i_valid}, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("strobe_kind", {62'd0, w_valid, i_valid}, {62'd0, e.isw, ~e.isw});
            chk("word_data", e.isw ? w_data : i_data, e.data);
            chk("word_ctrl", {62'd0, ctrl}, {62'd0, e.ctl});
            chk("word_wgroup", {60'd0, wgroup}, {60'd0, e.grp});
         end
      end
   end

   task automatic check_reset_values();
      chk("rst_mem_rd_en", {63'd0, mem_rd_en}, 64'd0);
      chk("rst_mem_addr", {48'd0, mem_addr}, 64'd0);
      chk("rst_valids", {62'd0, w_valid, i_valid}, 64'd0);
      chk("rst_data", w_data | i_data, 64'd0);
      chk("rst_ctrl", {62'd0, ctrl}, 64'd2);
      chk("rst_fields", {49'd0, Wsize, wgroup, wround, stride, RLPadding}, 64'd0);
      chk("rst_status", {61'd0, busy, done, cfg_err}, 64'd0);
   endtask

   // Reference: the whole job expressed as the list of words IPF must see.
   task automatic start_job(input logic [1:0] ws, input logic [3:0] ng,
                            input logic [15:0] wb, input logic [15:0] ib,
                            input logic st, input logic [1:0] rp);
      int wn;
      exp_t e;
      wn = (ws == 2'd1) ? 25 : 18;
      for (int k = 0; k < wn; k++) begin
         e.isw = 1'b1; e.data = memf(wb + 16'(k)); e.ctl = 2'd2; e.grp = 4'd0;
         q.push_back(e);
      end
      for (int g = 0; g < int'(ng); g++) begin
         for (int k = 0; k < 8; k++) begin
            e.isw = 1'b0; e.data = memf(ib + 16'(k));
            e.ctl = (k < 2) ? 2'd2 : 2'd1; e.grp = 4'(g);
            q.push_back(e);
         end
      end
      @(negedge clk);
      cfg_start = 1'b1; cfg_wsize = ws; cfg_ngroup = ng;
      cfg_wbase = wb; cfg_ibase = ib; cfg_stride = st; cfg_rlpad = rp;
      @(posedge clk);
      @(negedge clk);
      cfg_start = 1'b0;
      cfg_wsize = 2'($urandom); cfg_ngroup = 4'($urandom);
      cfg_wbase = 16'($urandom); cfg_ibase = 16'($urandom);
      cfg_stride = 1'($urandom); cfg_rlpad = 2'($urandom);
   endtask

   task automatic run_job(input logic [1:0] ws, input logic [3:0] ng,
                          input logic [15:0] wb, input logic [15:0] ib,
                          input int fin_delay);
      int wn, n, reads, nstrb, first, last, endc, notbusy, bad;
      logic st;
      logic [1:0] rp;
      st = 1'($urandom); rp = 2'($urandom);
      wn = (ws == 2'd1) ? 25 : 18;
      n  = wn + 8 * int'(ng);
      reads = 0; nstrb = 0; first = -1; last = -1; endc = -1; notbusy = 0;
      start_job(ws, ng, wb, ib, st, rp);
      // Now at the first negedge after the start was accepted (c = 0).
      for (int c = 0; c < 3000; c++) begin
         if (mem_rd_en) reads++;
         if (w_valid || i_valid) begin
            nstrb++;
            if (first < 0) first = c;
            last = c;
         end
         if (!busy) notbusy++;
         if (ctrl == 2'd0) begin
            endc = c;
            break;
         end
         // Disturbances that must be ignored: finish in LOADW, start in RUN.
         ipf_finish = (c == 3);
         cfg_start  = (c == wn + 4);
         @(negedge clk);
      end
      cfg_start = 1'b0; ipf_finish = 1'b0;
      chk("end_cycle", 64'(endc), 64'(n + 2));
      chk("read_count", 64'(reads), 64'(n));
      chk("strobe_count", 64'(nstrb), 64'(n));
      chk("first_strobe", 64'(first), 64'd2);
      chk("no_bubbles", 64'(last - first + 1), 64'(n));
      chk("busy_in_job", 64'(notbusy), 64'd0);
      chk("latched_cfg", {59'd0, Wsize, stride, RLPadding}, {59'd0, ws, st, rp});
      bad = 0;
      repeat (fin_delay) begin
         @(negedge clk);
         if (ctrl !== 2'd0 || busy !== 1'b1 || done !== 1'b0 || mem_rd_en !== 1'b0) bad++;
      end
      chk("endw_hold", 64'(bad), 64'd0);
      ipf_finish = 1'b1;
      @(negedge clk);
      ipf_finish = 1'b0;
      chk("done_pulse", {61'd0, done, busy, 1'b0}, {61'd0, 1'b1, 1'b0, 1'b0});
      chk("ctrl_after_done", {62'd0, ctrl}, 64'd2);
      @(negedge clk);
      chk("done_one_cycle", {62'd0, done, busy}, 64'd0);
      chk("queue_drained", 64'(q.size()), 64'd0);
   endtask

   task automatic cfg_bad(input logic [1:0] ws, input logic [3:0] ng);
      @(negedge clk);
      cfg_start = 1'b1; cfg_wsize = ws; cfg_ngroup = ng;
      @(negedge clk);
      cfg_start = 1'b0;
      chk("cfg_err_pulse", {61'd0, cfg_err, busy, mem_rd_en}, {61'd0, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      chk("cfg_err_after", {61'd0, cfg_err, busy, mem_rd_en}, 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_values();
      rst = 1'b1;
      @(negedge clk);

      run_job(2'd0, 4'd2, 16'h0000, 16'h0040, 3);
      run_job(2'd0, 4'd1, 16'h0100, 16'h0200, 50);
      run_job(2'd1, 4'd1, 16'h1000, 16'h2000, 2);

      cfg_bad(2'd2, 4'd3);
      cfg_bad(2'd3, 4'd1);
      cfg_bad(2'd0, 4'd0);

      // Abort in the middle of RUN, then a clean job.
      start_job(2'd0, 4'd2, 16'h0300, 16'h0400, 1'b1, 2'd3);
      repeat (18 + 4) @(negedge clk);
      #2 rst = 1'b0;
      #1 check_reset_values();
      q.delete();
      @(negedge clk);
      rst = 1'b1;
      run_job(2'd1, 4'd3, 16'h0500, 16'h0600, 1);

      // Address wrap-around.
      run_job(2'd1, 4'd2, 16'hFFF0, 16'hFFFC, 4);

      for (int j = 0; j < 4; j++) begin
         run_job(2'($urandom_range(0, 1)), 4'($urandom_range(1, 4)),
                 16'($urandom), 16'($urandom), $urandom_range(0, 6));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
